igcn_island_dispatcher: RTL and testbench
=========================================

IGCN_ISLAND_DISPATCHER -- requirements
Module: igcn_island_dispatcher

Interface
REQ-001 SHALL have parameter NUM_PES, default 4, PE count of downstream accelerator.
REQ-002 SHALL have parameter C_MAX, default 32, max nodes per PE chunk.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, raw-island queue depth (power of 2, >=2).
REQ-004 SHALL have port clk  input  1  single clock, rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have ports isl_valid input 1, isl_ready output 1, isl_size input 16, isl_last input 1: raw island stream, transfer when valid&&ready; last marks final island of batch.
REQ-007 SHALL have port strategy_is_enhanced  input  1  0=baseline, 1=enhanced chunking.
REQ-008 SHALL have ports start_processing output 1, island_size output 16, island_needs_penalty output 1, strategy_out output 1: chunk request to accelerator.
REQ-009 SHALL have ports island_accepted input 1, processing_done input 1: accelerator acceptance pulse and idle/done level.
REQ-010 SHALL have ports dispatcher_busy output 1, batch_done output 1.

Function
REQ-011 SHALL buffer raw islands in a FIFO_DEPTH-entry FIFO; isl_ready = !full; push and pop in same cycle allowed when full.
REQ-012 SHALL implement FSM IDLE -> LOAD -> ISSUE -> WAIT_ACK -> (ISSUE | IDLE).
REQ-013 IDLE: when FIFO non-empty, pop head, latch remaining=size, latch strategy, go LOAD.
REQ-014 LOAD: limit = C_MAX if latched strategy=0 or NUM_PES<2, else 2*C_MAX; penalty = (raw > limit); go ISSUE.
REQ-015 ISSUE: drive start_processing=1 for exactly one cycle with island_size=min(remaining,limit), island_needs_penalty=penalty, strategy_out=latched strategy; go WAIT_ACK.
REQ-016 WAIT_ACK: hold island_size/penalty/strategy_out stable; on island_accepted, remaining -= chunk; if remaining>0 go ISSUE else IDLE.
REQ-017 island_accepted outside WAIT_ACK SHALL be ignored.
REQ-018 Raw size 0 SHALL be popped and discarded, no chunk issued, FSM returns IDLE.
REQ-019 raw == limit SHALL produce one chunk, penalty 0; raw == limit+1 SHALL produce chunks limit,1 with penalty 1.
REQ-020 strategy_is_enhanced changes mid-island SHALL NOT affect chunks of the latched island.
REQ-021 Minimum latency: island pushed cycle t -> start_processing at t+3 (FIFO t+1 visible, IDLE pop, LOAD, ISSUE).
REQ-022 Remaining/chunk arithmetic SHALL be 17-bit internal, island_size 16-bit output; limit never exceeds 2*C_MAX.
REQ-023 dispatcher_busy = FSM!=IDLE or FIFO non-empty.
REQ-024 batch_done SHALL assert (level) when last-flagged island fully accepted, FIFO empty, FSM IDLE and processing_done=1; cleared on next accepted isl_valid.

Reset
REQ-025 On rst_n low SHALL asynchronously clear FIFO, FSM=IDLE, start_processing=0, island_size=0, island_needs_penalty=0, strategy_out=0, dispatcher_busy=0, batch_done=0, isl_ready=0.
REQ-026 isl_ready SHALL go 1 first clock after rst_n release; reset mid-island SHALL discard in-flight chunks, no further start_processing.

Configuration
REQ-027 With IGCN_DISPATCH_STATS_EN defined SHALL add outputs chunk_count[31:0], penalty_chunk_count[31:0] (incremented on each accepted chunk / accepted penalty chunk, saturating, reset 0).
REQ-028 Without IGCN_DISPATCH_STATS_EN those ports and counters SHALL not exist; all other behaviour identical.

Structure
REQ-029 Package igcn_pkg SHALL hold FSM state enum, default C_MAX/NUM_PES constants, island-size width constant.
REQ-030 FIFO SHALL be sub-module igcn_island_fifo (parameterised depth/width, full/empty).

Verification (C_MAX=32, NUM_PES=4)
REQ-031 Baseline, raw 16 -> one start, size 16, penalty 0; then accept -> IDLE.
REQ-032 Baseline, raw 42 -> chunks 32,10, both penalty 1, second start only after first accept.
REQ-033 Enhanced, raw 57 -> one chunk 57 penalty 0; raw 80 -> chunks 64,16 penalty 1.
REQ-034 Push 9 islands with accept held low -> isl_ready=0 after FIFO fills, no data lost after accepts resume.
REQ-035 Raw 0 then raw 32 baseline -> only one start, size 32 penalty 0; last flag + processing_done=1 -> batch_done=1.
REQ-036 Assert rst_n low during WAIT_ACK of raw 80 -> all outputs 0 immediately, no further starts.

Source files
------------

// File: rtl/igcn_pkg.sv
// ---------------------------------------------------------------------------
// igcn_pkg
// Shared definitions for the island dispatcher slice:
//   - default chunk size (C_MAX) and downstream PE count (NUM_PES)
//   - raw island size width and the 17-bit internal remaining/chunk width
//   - dispatcher FSM state enum
//   - clamp_chunk helper: min(remaining, limit) narrowed to the output width
// ---------------------------------------------------------------------------
package igcn_pkg;

    localparam int ISL_SIZE_W      = 16;
    localparam int REM_W           = ISL_SIZE_W + 1;
    localparam int C_MAX_DEFAULT   = 32;
    localparam int NUM_PES_DEFAULT = 4;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_LOAD     = 2'd1,
        ST_ISSUE    = 2'd2,
        ST_WAIT_ACK = 2'd3
    } disp_state_t;

    // The limit never exceeds 2*C_MAX, so the saturation branch is only a
    // guard that keeps every bit of the 17-bit minimum meaningful.
    function automatic logic [ISL_SIZE_W-1:0] clamp_chunk(
        input logic [REM_W-1:0] remaining,
        input logic [REM_W-1:0] limit
    );
        logic [REM_W-1:0] m;
        m = (remaining < limit) ? remaining : limit;
        return m[REM_W-1] ? '1 : m[ISL_SIZE_W-1:0];
    endfunction

endpackage

// File: rtl/igcn_island_fifo.sv
// ---------------------------------------------------------------------------
// igcn_island_fifo
// Raw-island queue with first-word fall-through read data.
// Parameters: DEPTH (power of 2, >= 2), WIDTH (entry width).
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   push, push_data     write request and data
//   pop,  pop_data      read request; pop_data always shows the head entry
//   full, empty         occupancy flags
// A push while full is taken only when a pop happens in the same cycle.
// ---------------------------------------------------------------------------
module igcn_island_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 17
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign pop_data = mem[rd_ptr];

    // Storage needs no reset: the count decides which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two; the count
    // carries one extra bit so full and empty are distinguishable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/igcn_island_dispatcher.sv
// ---------------------------------------------------------------------------
// igcn_island_dispatcher
// Queues raw islands and splits each into accelerator-sized chunks.
// Parameters: NUM_PES, C_MAX (max nodes per PE chunk), FIFO_DEPTH.
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   isl_valid/isl_ready/isl_size/isl_last   raw island stream
//   strategy_is_enhanced             0 = baseline, 1 = enhanced chunking
//   start_processing, island_size,
//   island_needs_penalty, strategy_out      chunk request to accelerator
//   island_accepted, processing_done        accelerator handshake/status
//   dispatcher_busy, batch_done             status
// Optional: define IGCN_DISPATCH_STATS_EN to add saturating chunk_count and
// penalty_chunk_count outputs.
// ---------------------------------------------------------------------------
module igcn_island_dispatcher
    import igcn_pkg::*;
#(
    parameter int NUM_PES    = NUM_PES_DEFAULT,
    parameter int C_MAX      = C_MAX_DEFAULT,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  isl_valid,
    output logic                  isl_ready,
    input  logic [ISL_SIZE_W-1:0] isl_size,
    input  logic                  isl_last,
    input  logic                  strategy_is_enhanced,
    output logic                  start_processing,
    output logic [ISL_SIZE_W-1:0] island_size,
    output logic                  island_needs_penalty,
    output logic                  strategy_out,
    input  logic                  island_accepted,
    input  logic                  processing_done,
    output logic                  dispatcher_busy,
`ifdef IGCN_DISPATCH_STATS_EN
    output logic [31:0]           chunk_count,
    output logic [31:0]           penalty_chunk_count,
`endif
    output logic                  batch_done
);

    localparam logic [REM_W-1:0] LIMIT_BASE = REM_W'(C_MAX);
    localparam logic [REM_W-1:0] LIMIT_ENH  = (NUM_PES < 2) ? REM_W'(C_MAX) : REM_W'(2 * C_MAX);

    disp_state_t            state;
    logic [REM_W-1:0]       remaining;
    logic [REM_W-1:0]       limit_q;
    logic [REM_W-1:0]       limit_sel;
    logic [REM_W-1:0]       rem_after;
    logic                   strat_q;
    logic                   last_q;
    logic                   ready_en;
    logic                   batch_pending;
    logic                   chunk_done;
    logic                   island_finished;
    logic                   fifo_push;
    logic                   fifo_pop;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [ISL_SIZE_W:0]    fifo_dout;

    // ready_en holds isl_ready low through reset and for the edge it is released on.
    assign isl_ready       = ready_en && !fifo_full;
    assign fifo_push       = isl_valid && isl_ready;
    assign fifo_pop        = (state == ST_IDLE) && !fifo_empty;
    assign dispatcher_busy = (state != ST_IDLE) || !fifo_empty;
    assign limit_sel       = strat_q ? LIMIT_ENH : LIMIT_BASE;
    assign rem_after       = remaining - {1'b0, island_size};
    assign chunk_done      = (state == ST_WAIT_ACK) && island_accepted;
    assign island_finished = ((state == ST_LOAD) && (remaining == '0)) ||
                             (chunk_done && (rem_after == '0));

    igcn_island_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ISL_SIZE_W + 1)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data ({isl_last, isl_size}),
        .pop       (fifo_pop),
        .pop_data  (fifo_dout),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Chunking FSM. Request outputs are registered and change only on the
    // edges that enter ISSUE, so they stay stable for the whole WAIT_ACK.
    // Strategy is latched at pop time so later input changes cannot alter
    // an island already being chunked. Zero-size islands fall out of LOAD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state                <= ST_IDLE;
            remaining            <= '0;
            limit_q              <= '0;
            strat_q              <= 1'b0;
            last_q               <= 1'b0;
            ready_en             <= 1'b0;
            start_processing     <= 1'b0;
            island_size          <= '0;
            island_needs_penalty <= 1'b0;
            strategy_out         <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        remaining <= {1'b0, fifo_dout[ISL_SIZE_W-1:0]};
                        last_q    <= fifo_dout[ISL_SIZE_W];
                        strat_q   <= strategy_is_enhanced;
                        state     <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (remaining == '0) begin
                        state <= ST_IDLE;
                    end else begin
                        limit_q              <= limit_sel;
                        island_needs_penalty <= (remaining > limit_sel);
                        island_size          <= clamp_chunk(remaining, limit_sel);
                        strategy_out         <= strat_q;
                        start_processing     <= 1'b1;
                        state                <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    start_processing <= 1'b0;
                    state            <= ST_WAIT_ACK;
                end
                ST_WAIT_ACK: begin
                    if (island_accepted) begin
                        remaining <= rem_after;
                        if (rem_after != '0) begin
                            island_size      <= clamp_chunk(rem_after, limit_q);
                            start_processing <= 1'b1;
                            state            <= ST_ISSUE;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // batch_pending remembers that the last-flagged island has been fully
    // consumed; batch_done then follows the idle conditions as a level and
    // both clear as soon as a new island is accepted on the input stream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            batch_pending <= 1'b0;
            batch_done    <= 1'b0;
        end else if (fifo_push) begin
            batch_pending <= 1'b0;
            batch_done    <= 1'b0;
        end else begin
            if (island_finished && last_q) begin
                batch_pending <= 1'b1;
            end
            batch_done <= batch_pending && fifo_empty && (state == ST_IDLE) && processing_done;
        end
    end

`ifdef IGCN_DISPATCH_STATS_EN
    // Saturating statistics, stepped once per accepted chunk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chunk_count         <= '0;
            penalty_chunk_count <= '0;
        end else if (chunk_done) begin
            if (chunk_count != '1) begin
                chunk_count <= chunk_count + 1'b1;
            end
            if (island_needs_penalty && (penalty_chunk_count != '1)) begin
                penalty_chunk_count <= penalty_chunk_count + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_igcn_island_dispatcher.sv
// ---------------------------------------------------------------------------
// tb_igcn_island_dispatcher
// Directed bench for igcn_island_dispatcher with C_MAX=32, NUM_PES=4.
// ---------------------------------------------------------------------------
module tb_igcn_island_dispatcher;

    logic        clk;
    logic        rst_n;
    logic        isl_valid;
    logic        isl_ready;
    logic [15:0] isl_size;
    logic        isl_last;
    logic        strategy_is_enhanced;
    logic        start_processing;
    logic [15:0] island_size;
    logic        island_needs_penalty;
    logic        strategy_out;
    logic        island_accepted;
    logic        processing_done;
    logic        dispatcher_busy;
    logic        batch_done;
`ifdef IGCN_DISPATCH_STATS_EN
    logic [31:0] chunk_count;
    logic [31:0] penalty_chunk_count;
`endif

    int passCount;
    int totalCount;

    igcn_island_dispatcher #(
        .NUM_PES    (4),
        .C_MAX      (32),
        .FIFO_DEPTH (8)
    ) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .isl_valid            (isl_valid),
        .isl_ready            (isl_ready),
        .isl_size             (isl_size),
        .isl_last             (isl_last),
        .strategy_is_enhanced (strategy_is_enhanced),
        .start_processing     (start_processing),
        .island_size          (island_size),
        .island_needs_penalty (island_needs_penalty),
        .strategy_out         (strategy_out),
        .island_accepted      (island_accepted),
        .processing_done      (processing_done),
        .dispatcher_busy      (dispatcher_busy),
`ifdef IGCN_DISPATCH_STATS_EN
        .chunk_count          (chunk_count),
        .penalty_chunk_count  (penalty_chunk_count),
`endif
        .batch_done           (batch_done)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        totalCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    endtask

    // Push one raw island, waiting a bounded time for isl_ready.
    task automatic applyStimulus(input logic [15:0] size, input logic last);
        int n;
        n = 0;
        isl_size  = size;
        isl_last  = last;
        isl_valid = 1'b1;
        while (!isl_ready && n < 40) begin
            tick();
            n++;
        end
        checkOutput("push_ready", {31'd0, isl_ready}, 32'd1);
        tick();
        isl_valid = 1'b0;
    endtask

    task automatic waitStart(input string tag);
        int n;
        n = 0;
        while (!start_processing && n < 20) begin
            tick();
            n++;
        end
        checkOutput(tag, {31'd0, start_processing}, 32'd1);
    endtask

    task automatic acceptChunk();
        island_accepted = 1'b1;
        tick();
        island_accepted = 1'b0;
    endtask

    // Linear sequence of directed steps with hand-computed expectations.
    initial begin
        passCount            = 0;
        totalCount           = 0;
        rst_n                = 1'b0;
        isl_valid            = 1'b0;
        isl_size             = 16'd0;
        isl_last             = 1'b0;
        strategy_is_enhanced = 1'b0;
        island_accepted      = 1'b0;
        processing_done      = 1'b1;

        // Reset state
        #1;
        checkOutput("rst_ready", {31'd0, isl_ready}, 32'd0);
        checkOutput("rst_start", {31'd0, start_processing}, 32'd0);
        checkOutput("rst_busy", {31'd0, dispatcher_busy}, 32'd0);
        checkOutput("rst_batch", {31'd0, batch_done}, 32'd0);
        checkOutput("rst_size", {16'd0, island_size}, 32'd0);
        #20;
        rst_n = 1'b1;
        #1;
        checkOutput("ready_before_edge", {31'd0, isl_ready}, 32'd0);
        tick();
        checkOutput("ready_after_edge", {31'd0, isl_ready}, 32'd1);

        // Baseline 16: one chunk, minimum latency
        $display("[TB] baseline raw 16");
        applyStimulus(16'd16, 1'b0);
        tick();
        checkOutput("b16_no_start_yet", {31'd0, start_processing}, 32'd0);
        checkOutput("b16_busy", {31'd0, dispatcher_busy}, 32'd1);
        tick();
        checkOutput("b16_start", {31'd0, start_processing}, 32'd1);
        checkOutput("b16_size", {16'd0, island_size}, 32'd16);
        checkOutput("b16_pen", {31'd0, island_needs_penalty}, 32'd0);
        checkOutput("b16_strat", {31'd0, strategy_out}, 32'd0);
        tick();
        checkOutput("b16_start_pulse", {31'd0, start_processing}, 32'd0);
        checkOutput("b16_size_hold", {16'd0, island_size}, 32'd16);
        acceptChunk();
        checkOutput("b16_idle_busy", {31'd0, dispatcher_busy}, 32'd0);
        checkOutput("b16_idle_start", {31'd0, start_processing}, 32'd0);

        // Baseline 42: chunks 32,10 penalty 1; accept during ISSUE ignored
        $display("[TB] baseline raw 42");
        applyStimulus(16'd42, 1'b0);
        tick();
        tick();
        checkOutput("b42_start1", {31'd0, start_processing}, 32'd1);
        checkOutput("b42_size1", {16'd0, island_size}, 32'd32);
        checkOutput("b42_pen1", {31'd0, island_needs_penalty}, 32'd1);
        island_accepted = 1'b1;
        tick();
        island_accepted = 1'b0;
        checkOutput("b42_ignored_acc_size", {16'd0, island_size}, 32'd32);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("b42_no_early_start", {31'd0, start_processing}, 32'd0);
        end
        acceptChunk();
        checkOutput("b42_start2", {31'd0, start_processing}, 32'd1);
        checkOutput("b42_size2", {16'd0, island_size}, 32'd10);
        checkOutput("b42_pen2", {31'd0, island_needs_penalty}, 32'd1);
        tick();
        acceptChunk();
        checkOutput("b42_idle", {31'd0, dispatcher_busy}, 32'd0);

        // Enhanced 57 then 80, strategy toggled after latching
        $display("[TB] enhanced raw 57 and 80");
        strategy_is_enhanced = 1'b1;
        applyStimulus(16'd57, 1'b0);
        tick();
        strategy_is_enhanced = 1'b0;
        tick();
        checkOutput("e57_start", {31'd0, start_processing}, 32'd1);
        checkOutput("e57_size", {16'd0, island_size}, 32'd57);
        checkOutput("e57_pen", {31'd0, island_needs_penalty}, 32'd0);
        checkOutput("e57_strat", {31'd0, strategy_out}, 32'd1);
        tick();
        acceptChunk();
        checkOutput("e57_idle", {31'd0, dispatcher_busy}, 32'd0);
        strategy_is_enhanced = 1'b1;
        applyStimulus(16'd80, 1'b0);
        tick();
        strategy_is_enhanced = 1'b0;
        tick();
        checkOutput("e80_size1", {16'd0, island_size}, 32'd64);
        checkOutput("e80_pen1", {31'd0, island_needs_penalty}, 32'd1);
        checkOutput("e80_strat1", {31'd0, strategy_out}, 32'd1);
        tick();
        acceptChunk();
        checkOutput("e80_start2", {31'd0, start_processing}, 32'd1);
        checkOutput("e80_size2", {16'd0, island_size}, 32'd16);
        checkOutput("e80_pen2", {31'd0, island_needs_penalty}, 32'd1);
        checkOutput("e80_strat2", {31'd0, strategy_out}, 32'd1);
        tick();
        acceptChunk();
        checkOutput("e80_idle", {31'd0, dispatcher_busy}, 32'd0);

        // Nine islands with accept held low: FIFO fills, nothing lost
        $display("[TB] fifo fill");
        for (int i = 1; i <= 9; i++) begin
            applyStimulus(16'(i), 1'b0);
        end
        checkOutput("fill_ready_low", {31'd0, isl_ready}, 32'd0);
        checkOutput("fill_first_size", {16'd0, island_size}, 32'd1);
        acceptChunk();
        for (int i = 2; i <= 9; i++) begin
            waitStart("fill_start");
            checkOutput("fill_size", {16'd0, island_size}, 32'(i));
            tick();
            acceptChunk();
        end
        checkOutput("fill_drained_busy", {31'd0, dispatcher_busy}, 32'd0);
        checkOutput("fill_ready_back", {31'd0, isl_ready}, 32'd1);

        // Raw 0 discarded, raw 32 last -> single chunk, then batch_done
        $display("[TB] zero island and batch done");
        applyStimulus(16'd0, 1'b0);
        applyStimulus(16'd32, 1'b1);
        waitStart("z_start");
        checkOutput("z_size", {16'd0, island_size}, 32'd32);
        checkOutput("z_pen", {31'd0, island_needs_penalty}, 32'd0);
        tick();
        processing_done = 1'b0;
        acceptChunk();
        tick();
        checkOutput("batch_wait_done", {31'd0, batch_done}, 32'd0);
        processing_done = 1'b1;
        tick();
        checkOutput("batch_done_set", {31'd0, batch_done}, 32'd1);
        applyStimulus(16'd0, 1'b0);
        checkOutput("batch_done_clear", {31'd0, batch_done}, 32'd0);
        tick();
        tick();
        checkOutput("z_discard_idle", {31'd0, dispatcher_busy}, 32'd0);

        // Reset during WAIT_ACK of raw 80
        $display("[TB] reset mid island");
        strategy_is_enhanced = 1'b1;
        applyStimulus(16'd80, 1'b0);
        waitStart("r80_start");
        checkOutput("r80_size", {16'd0, island_size}, 32'd64);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("r80_start0", {31'd0, start_processing}, 32'd0);
        checkOutput("r80_size0", {16'd0, island_size}, 32'd0);
        checkOutput("r80_pen0", {31'd0, island_needs_penalty}, 32'd0);
        checkOutput("r80_strat0", {31'd0, strategy_out}, 32'd0);
        checkOutput("r80_busy0", {31'd0, dispatcher_busy}, 32'd0);
        checkOutput("r80_ready0", {31'd0, isl_ready}, 32'd0);
        checkOutput("r80_batch0", {31'd0, batch_done}, 32'd0);
        island_accepted = 1'b1;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("r80_no_restart", {31'd0, start_processing}, 32'd0);
        end
        island_accepted = 1'b0;
        checkOutput("r80_ready_back", {31'd0, isl_ready}, 32'd1);
        checkOutput("r80_busy_after", {31'd0, dispatcher_busy}, 32'd0);

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
